// File: rtl/time_pkg.sv
// Shared encodings for the time-set sequencer: mode codes and counter field selects.
package time_pkg;

   localparam logic [1:0] MODE_RUN      = 2'b00;
   localparam logic [1:0] MODE_SET_HOUR = 2'b01;
   localparam logic [1:0] MODE_SET_MIN  = 2'b10;
   localparam logic [1:0] MODE_SET_SEC  = 2'b11;

   // Bit positions of each field inside the packed en/inc/dec vectors
   localparam logic [1:0] FIELD_SEC  = 2'd0;
   localparam logic [1:0] FIELD_MIN  = 2'd1;
   localparam logic [1:0] FIELD_HOUR = 2'd2;

   // Set-mode cycle order: RUN -> HOUR -> MIN -> SEC -> RUN
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      case (m)
         MODE_RUN:      return MODE_SET_HOUR;
         MODE_SET_HOUR: return MODE_SET_MIN;
         MODE_SET_MIN:  return MODE_SET_SEC;
         default:       return MODE_RUN;
      endcase
   endfunction

   // Field edited in a given SET mode (RUN maps to sec, never used there)
   function automatic logic [1:0] mode_field(input logic [1:0] m);
      case (m)
         MODE_SET_HOUR: return FIELD_HOUR;
         MODE_SET_MIN:  return FIELD_MIN;
         default:       return FIELD_SEC;
      endcase
   endfunction

endpackage

// File: rtl/idle_timer.sv
// Tick-driven saturating idle counter. The timeout strobe fires combinationally
// in the cycle of the tick that completes TIMEOUT_TICKS, so the FSM can leave
// SET on the very next edge.
module idle_timer #(
   parameter int TIMEOUT_TICKS = 10,
   parameter int TO_BITS       = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic clr,
   output logic timeout
);

   localparam logic [TO_BITS-1:0] LAST = TO_BITS'(TIMEOUT_TICKS - 1);
   localparam logic [TO_BITS-1:0] SAT  = TO_BITS'(TIMEOUT_TICKS);

   logic [TO_BITS-1:0] cnt_q;

   // clear has priority: a press or mode change in the final tick cycle restarts the count
   assign timeout = tick & ~clr & (cnt_q == LAST);

   // count ticks, restart on clear or on timeout, never wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                cnt_q <= '0;
      else if (clr || timeout)     cnt_q <= '0;
      else if (tick && cnt_q != SAT) cnt_q <= cnt_q + 1'b1;
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-field sequencer: RUN carry chain and hour->min->sec set mode with idle timeout.
// Strobes are a zero-latency decode of the registered mode and current inputs.
module time_set_ctrl
   import time_pkg::*;
#(
   parameter int TIMEOUT_TICKS = 10,
   parameter int TO_BITS       = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       sec_done_inc,
   input  logic       min_done_inc,
   output logic       sec_en,
   output logic       sec_inc,
   output logic       sec_dec,
   output logic       min_en,
   output logic       min_inc,
   output logic       min_dec,
   output logic       hour_en,
   output logic       hour_inc,
   output logic       hour_dec,
   output logic [1:0] mode_o,
   output logic       blink_o
);

   logic [1:0] state_q, state_d;
   logic       blink_q, blink_d;
   logic       in_set, press_up, press_dn, press_vld;
   logic       idle_clr, idle_to;
   logic [2:0] en, inc, dec;

   assign in_set    = (state_q != MODE_RUN);
   // up and down together is treated as no press at all
   assign press_up  = in_set & btn_up & ~btn_down;
   assign press_dn  = in_set & btn_down & ~btn_up;
   assign press_vld = press_up | press_dn;

   // held at zero in RUN, restarted on any SET entry and every valid press
   assign idle_clr = ~in_set | btn_mode | press_vld;

   idle_timer #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS),
      .TO_BITS       (TO_BITS)
   ) u_idle_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick_1hz),
      .clr     (idle_clr),
      .timeout (idle_to)
   );

   // next mode: button advances, idle timeout drops back to RUN
   always_comb begin
      state_d = state_q;
      if (btn_mode)     state_d = next_mode(state_q);
      else if (idle_to) state_d = MODE_RUN;
   end

   // blink: off in RUN, solid on entry/press, toggles on ticks otherwise
   always_comb begin
      blink_d = blink_q;
      if (state_d == MODE_RUN)                      blink_d = 1'b0;
      else if (state_d != state_q || press_vld)     blink_d = 1'b1;
      else if (tick_1hz)                            blink_d = ~blink_q;
   end

   // registered mode and blink
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MODE_RUN;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
      end
   end

   // strobe decode: carry chain in RUN, single selected field in SET
   always_comb begin
      en  = '0;
      inc = '0;
      dec = '0;
      if (!in_set) begin
         inc            = '1;
         en[FIELD_SEC]  = tick_1hz;
         en[FIELD_MIN]  = tick_1hz & sec_done_inc;
         en[FIELD_HOUR] = tick_1hz & sec_done_inc & min_done_inc;
      end else begin
         en[mode_field(state_q)]  = press_vld;
         inc[mode_field(state_q)] = press_up;
         dec[mode_field(state_q)] = press_dn;
      end
   end

   assign sec_en   = en[FIELD_SEC];
   assign sec_inc  = inc[FIELD_SEC];
   assign sec_dec  = dec[FIELD_SEC];
   assign min_en   = en[FIELD_MIN];
   assign min_inc  = inc[FIELD_MIN];
   assign min_dec  = dec[FIELD_MIN];
   assign hour_en  = en[FIELD_HOUR];
   assign hour_inc = inc[FIELD_HOUR];
   assign hour_dec = dec[FIELD_HOUR];
   assign mode_o   = state_q;
   assign blink_o  = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios with literal expectations, then
// random stimulus checked every cycle against a behavioural model.
module tb_time_set_ctrl;

   localparam int TO = 10;

   logic clk = 1'b0;
   logic reset_n;
   logic tick_1hz, btn_mode, btn_up, btn_down, sec_done_inc, min_done_inc;
   logic sec_en, sec_inc, sec_dec, min_en, min_inc, min_dec;
   logic hour_en, hour_inc, hour_dec, blink_o;
   logic [1:0] mode_o;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state: mode number 0..3, idle tick count, blink
   int m_mode;
   int m_idle;
   bit m_blink;

   time_set_ctrl #(.TIMEOUT_TICKS(TO), .TO_BITS(4)) dut (
      .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
      .btn_up(btn_up), .btn_down(btn_down), .sec_done_inc(sec_done_inc),
      .min_done_inc(min_done_inc),
      .sec_en(sec_en), .sec_inc(sec_inc), .sec_dec(sec_dec),
      .min_en(min_en), .min_inc(min_inc), .min_dec(min_dec),
      .hour_en(hour_en), .hour_inc(hour_inc), .hour_dec(hour_dec),
      .mode_o(mode_o), .blink_o(blink_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model update: what the clock must do on each edge, from the rules
   always @(posedge clk or negedge reset_n) begin
      int nm, ni;
      bit nb, press;
      if (!reset_n) begin
         m_mode  <= 0;
         m_idle  <= 0;
         m_blink <= 1'b0;
      end else begin
         nm = m_mode; ni = m_idle; nb = m_blink;
         press = (m_mode != 0) && (btn_up != btn_down);
         if (m_mode == 0) begin
            ni = 0; nb = 1'b0;
            if (btn_mode) begin nm = 1; nb = 1'b1; end
         end else if (btn_mode) begin
            nm = (m_mode + 1) % 4; ni = 0; nb = (nm != 0);
         end else if (press) begin
            ni = 0; nb = 1'b1;
         end else if (tick_1hz) begin
            ni = m_idle + 1; nb = ~m_blink;
            if (ni >= TO) begin nm = 0; ni = 0; nb = 1'b0; end
         end
         m_mode  <= nm;
         m_idle  <= ni;
         m_blink <= nb;
      end
   end

   // compare process: expected outputs from model state plus current inputs
   always @(negedge clk) begin
      logic [2:0] e_en, e_inc, e_dec;
      int f;
      e_en = '0; e_inc = '0; e_dec = '0;
      if (m_mode == 0) begin
         e_inc   = 3'b111;
         e_en[0] = tick_1hz;
         e_en[1] = tick_1hz & sec_done_inc;
         e_en[2] = tick_1hz & sec_done_inc & min_done_inc;
      end else begin
         f = 3 - m_mode; // 1->hour(2), 2->min(1), 3->sec(0)
         if (btn_up != btn_down) begin
            e_en[f] = 1'b1; e_inc[f] = btn_up; e_dec[f] = btn_down;
         end
      end
      chk("cycle_outputs",
          32'({hour_en, hour_inc, hour_dec, min_en, min_inc, min_dec,
               sec_en, sec_inc, sec_dec, mode_o, blink_o}),
          32'({e_en[2], e_inc[2], e_dec[2], e_en[1], e_inc[1], e_dec[1],
               e_en[0], e_inc[0], e_dec[0], 2'(m_mode), m_blink}));
   end

   task automatic drv(input logic t, m, u, d, sd, md);
      tick_1hz = t; btn_mode = m; btn_up = u; btn_down = d;
      sec_done_inc = sd; min_done_inc = md;
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_mode",  32'(mode_o), 32'd0);
      chk("rst_blink", 32'(blink_o), 32'd0);
      chk("rst_inc",   32'({hour_inc, min_inc, sec_inc}), 32'b111);
      chk("rst_en_dec", 32'({hour_en, min_en, sec_en, hour_dec, min_dec, sec_dec}), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // full carry: sec=59, min=59, tick
      drv(1, 0, 0, 0, 1, 1); @(negedge clk);
      chk("t1_en", 32'({hour_en, min_en, sec_en}), 32'b111);
      chk("t1_mode", 32'(mode_o), 32'd0);
      nxt();
      // sec=30: only sec advances
      drv(1, 0, 0, 0, 0, 0); @(negedge clk);
      chk("t2_en", 32'({hour_en, min_en, sec_en}), 32'b001);
      nxt();

      // enter SET_HOUR, three ups (one with a tick that must not advance time)
      drv(0, 1, 0, 0, 0, 0); nxt();
      for (int i = 0; i < 3; i++) begin
         drv(i == 1, 0, 1, 0, 1, 1); @(negedge clk);
         chk("t3_hour", 32'({hour_en, hour_inc, hour_dec}), 32'b110);
         chk("t3_other", 32'({sec_en, min_en}), 32'd0);
         nxt();
      end
      drv(0, 0, 0, 0, 0, 0); @(negedge clk);
      chk("t3_mode", 32'(mode_o), 32'd1);
      chk("t3_blink", 32'(blink_o), 32'd1);
      nxt();

      // SET_MIN: down, then up&down together
      drv(0, 1, 0, 0, 0, 0); nxt();
      drv(0, 0, 0, 1, 0, 0); @(negedge clk);
      chk("t4_down", 32'({min_en, min_inc, min_dec}), 32'b101);
      nxt();
      drv(0, 0, 1, 1, 0, 0); @(negedge clk);
      chk("t4_both", 32'({hour_en, min_en, sec_en}), 32'd0);
      nxt();

      // SET_SEC: 9 ticks, press on the 9th tick restarts, then 10 idle ticks
      drv(0, 1, 0, 0, 0, 0); nxt();
      for (int i = 0; i < 8; i++) begin
         drv(1, 0, 0, 0, 0, 0); nxt();
         drv(0, 0, 0, 0, 0, 0); nxt();
      end
      drv(1, 0, 1, 0, 0, 0); nxt();
      for (int i = 0; i < 9; i++) begin
         drv(1, 0, 0, 0, 0, 0); nxt();
         drv(0, 0, 0, 0, 0, 0); nxt();
      end
      @(negedge clk);
      chk("t5_hold", 32'(mode_o), 32'd3);
      nxt();
      drv(1, 0, 0, 0, 0, 0); nxt();
      drv(0, 0, 0, 0, 0, 0); @(negedge clk);
      chk("t5_timeout", 32'(mode_o), 32'd0);
      chk("t5_blink", 32'(blink_o), 32'd0);
      nxt();

      // async reset in the middle of SET_MIN
      drv(0, 1, 0, 0, 0, 0); nxt();
      drv(0, 1, 0, 0, 0, 0); nxt();
      drv(0, 0, 0, 0, 0, 0);
      chk("t6_pre", 32'(mode_o), 32'd2);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_mode", 32'(mode_o), 32'd0);
      chk("t6_blink", 32'(blink_o), 32'd0);
      chk("t6_inc", 32'({hour_inc, min_inc, sec_inc}), 32'b111);
      @(posedge clk); #1 reset_n = 1'b1;

      // random traffic, alternating busy and quiet phases so timeouts occur
      for (int i = 0; i < 6000; i++) begin
         bit quiet;
         quiet = ((i / 300) % 2) == 1;
         drv($urandom_range(3) == 0,
             $urandom_range(quiet ? 199 : 11) == 0,
             $urandom_range(quiet ? 39 : 4) == 0,
             $urandom_range(quiet ? 39 : 4) == 0,
             $urandom_range(1) == 1,
             $urandom_range(1) == 1);
         if (i == 3100) begin
            #2 reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         nxt();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
